// File: rtl/disp_pkg.sv
// Shared constants and types for the display scan multiplexer.
//   ALPH_DASH / ALPH_P : glyph codes beyond the hex range
//   NUM_DIGITS         : digits on the display
//   state_t            : display mode FSM encoding
package disp_pkg;

  localparam int unsigned ALPH_W     = 5;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIG_W      = $clog2(NUM_DIGITS);
  localparam int unsigned WORD_W     = 16;

  localparam logic [ALPH_W-1:0] ALPH_DASH = 5'd17;
  // Reserved glyph, not generated by this revision.
  localparam logic [ALPH_W-1:0] ALPH_P    = 5'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/disp_scan_mux_if.sv
// Bus between the cipher front end and the display scanner.
//   load/word_in/busy : driven by the master (cipher side)
//   alph/anode        : driven by the slave (scanner), toward the 7-seg driver
interface disp_scan_mux_if;
  import disp_pkg::*;

  logic                  load;
  logic [WORD_W-1:0]     word_in;
  logic                  busy;
  logic [ALPH_W-1:0]     alph;
  logic [NUM_DIGITS-1:0] anode;

  modport master (output load, output word_in, output busy,
                  input  alph, input  anode);
  modport slave  (input  load, input  word_in, input  busy,
                  output alph, output anode);
endinterface

// File: rtl/disp_refresh_tick.sv
// Free-running prescaler: cnt counts 0..REFRESH_DIV-1 and wraps; tick marks
// the last count of each digit slot.
//   clk, rst : clock, synchronous active-high reset
//   cnt      : current count within the slot
//   tick     : high while cnt == REFRESH_DIV-1
module disp_refresh_tick #(
  parameter  int unsigned REFRESH_DIV = 100000,
  localparam int unsigned CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);

  assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));

  // Slot counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/disp_scan_mux.sv
// Four-digit 7-segment scan multiplexer for the cipher result display.
// Shows the latched word as hex, or dashes while idle / while the core is busy.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side -- load/word_in/busy in, alph/anode out (registered)
module disp_scan_mux
  import disp_pkg::*;
#(
  parameter  int unsigned REFRESH_DIV = 100000,
  parameter  int unsigned BLANK_CYC   = 4,
  localparam int unsigned CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  disp_scan_mux_if.slave bus
);

  logic [CNT_W-1:0]      cnt;
  logic                  tick;
  logic [DIG_W-1:0]      dig;
  state_t                state;
  state_t                state_nxt;
  logic [WORD_W-1:0]     word_q;
  logic                  blank;
  logic [ALPH_W-1:0]     alph_c;
  logic [NUM_DIGITS-1:0] anode_c;
  logic [3:0]            nibble;

  disp_refresh_tick #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .tick (tick)
  );

  // Digit select advances once per slot, never stalled by the cipher side
  always_ff @(posedge clk) begin
    if (rst) begin
      dig <= '0;
    end else if (tick) begin
      dig <= dig + DIG_W'(1);
    end
  end

  // Result latch; loads arriving while busy are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
    end else if (bus.load && !bus.busy) begin
      word_q <= bus.word_in;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: busy overrides everything
  always_comb begin
    state_nxt = state;
    if (bus.busy) begin
      state_nxt = WAIT;
    end else begin
      unique case (state)
        WAIT:       state_nxt = bus.load ? SHOW : IDLE;
        IDLE, SHOW: state_nxt = bus.load ? SHOW : state;
        default:    state_nxt = IDLE;
      endcase
    end
  end

  // Anti-ghosting window at the start of each slot
  if (BLANK_CYC == 0) begin : g_no_blank
    assign blank = 1'b0;
  end else begin : g_blank
    assign blank = (cnt < CNT_W'(BLANK_CYC));
  end

  assign nibble = word_q[{dig, 2'b00} +: 4];

  // FSM output decode: glyph and digit enable for the current slot
  always_comb begin
    alph_c  = ALPH_DASH;
    anode_c = '1;
    if (state == SHOW) begin
      alph_c = {1'b0, nibble};
    end
    if (!blank) begin
      anode_c = ~(NUM_DIGITS'(1) << dig);
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alph  <= ALPH_DASH;
      bus.anode <= '1;
    end else begin
      bus.alph  <= alph_c;
      bus.anode <= anode_c;
    end
  end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Self-checking bench for disp_scan_mux: two instances (blanking 2 and 0)
// driven by the same directed + random stimulus, checked every cycle against
// a slot-arithmetic reference model.
module tb_disp_scan_mux;
  import disp_pkg::*;

  localparam int unsigned DIV = 8;
  localparam int unsigned BLK_A = 2;
  localparam int unsigned BLK_B = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  // Reference model: cycles since reset release, displayed word, show flag
  int          m_t = 0;
  logic [15:0] m_word = 16'h0000;
  bit          m_show = 1'b0;

  disp_scan_mux_if bus_a ();
  disp_scan_mux_if bus_b ();

  disp_scan_mux #(.REFRESH_DIV(DIV), .BLANK_CYC(BLK_A)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a.slave));
  disp_scan_mux #(.REFRESH_DIV(DIV), .BLANK_CYC(BLK_B)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b.slave));

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_anode(input int t, input int blk);
    int slot_pos;
    int d;
    logic [3:0] a;
    slot_pos = t % DIV;
    d = (t / DIV) % 4;
    a = 4'b1111;
    if (slot_pos >= blk) a[d] = 1'b0;
    return a;
  endfunction

  function automatic logic [4:0] exp_alph(input int t, input bit show, input logic [15:0] w);
    int d;
    d = (t / DIV) % 4;
    if (!show) return 5'd17;
    return 5'((w >> (4 * d)) & 16'hF);
  endfunction

  // One clock: drive inputs, predict registered outputs, advance model, check
  task automatic step(input logic r, input logic l, input logic [15:0] w, input logic b);
    logic [4:0] ea;
    logic [3:0] ena;
    logic [3:0] enb;
    @(negedge clk);
    rst = r;
    bus_a.load = l; bus_a.word_in = w; bus_a.busy = b;
    bus_b.load = l; bus_b.word_in = w; bus_b.busy = b;
    if (r) begin
      ea = 5'd17; ena = 4'b1111; enb = 4'b1111;
      m_t = 0; m_word = 16'h0000; m_show = 1'b0;
    end else begin
      ea  = exp_alph(m_t, m_show, m_word);
      ena = exp_anode(m_t, BLK_A);
      enb = exp_anode(m_t, BLK_B);
      m_t++;
      if (b) m_show = 1'b0;
      else if (l) begin
        m_show = 1'b1;
        m_word = w;
      end
    end
    @(posedge clk);
    #1;
    checks++;
    assert (bus_a.alph === ea) else begin
      errors++;
      $error("FAIL alph_a obs=%0d exp=%0d t=%0d", bus_a.alph, ea, m_t);
    end
    checks++;
    assert (bus_a.anode === ena) else begin
      errors++;
      $error("FAIL anode_a obs=%b exp=%b t=%0d", bus_a.anode, ena, m_t);
    end
    checks++;
    assert (bus_b.alph === ea) else begin
      errors++;
      $error("FAIL alph_b obs=%0d exp=%0d t=%0d", bus_b.alph, ea, m_t);
    end
    checks++;
    assert (bus_b.anode === enb) else begin
      errors++;
      $error("FAIL anode_b obs=%b exp=%b t=%0d", bus_b.anode, enb, m_t);
    end
  endtask

  task automatic idle(input int n, input logic b);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, b);
  endtask

  task automatic check_word(input string tag, input logic [15:0] exp);
    checks++;
    assert (dut_a.word_q === exp) else begin
      errors++;
      $error("FAIL %s word_q obs=%h exp=%h", tag, dut_a.word_q, exp);
    end
  endtask

  initial begin
    bus_a.load = 1'b0; bus_a.word_in = '0; bus_a.busy = 1'b0;
    bus_b.load = 1'b0; bus_b.word_in = '0; bus_b.busy = 1'b0;

    // Reset, then free scan with dashes
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    check_word("reset", 16'h0000);
    idle(40, 1'b0);

    // Load display
    step(1'b0, 1'b1, 16'hA3F0, 1'b0);
    idle(40, 1'b0);
    check_word("load", 16'hA3F0);

    // Busy priority with a load attempted during busy
    idle(8, 1'b1);
    step(1'b0, 1'b1, 16'h1234, 1'b1);
    idle(11, 1'b1);
    idle(20, 1'b0);
    check_word("busy_ignore", 16'hA3F0);

    // Busy falls together with a load
    idle(5, 1'b1);
    step(1'b0, 1'b1, 16'hBEEF, 1'b0);
    idle(36, 1'b0);
    check_word("busy_exit_load", 16'hBEEF);

    // Reset mid-slot in SHOW at cnt=5, dig=2
    while (!((m_t % DIV) == 5 && ((m_t / DIV) % 4) == 2)) idle(1, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    check_word("mid_reset", 16'h0000);
    idle(40, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0),
           16'($urandom), ($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/disp_scan_mux.md
DISP_SCAN_MUX -- requirements
Module: disp_scan_mux

Parameters, one per line: name, default, meaning.
- REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range is at least 4.
- REQ-002 The block SHALL have parameter BLANK_CYC, default 4, cycles at the start of each slot with all anodes off (anti-ghosting); legal range is 0 to REFRESH_DIV-1.

Interface, one per line: name, direction, width, meaning.
- REQ-003 `clk` SHALL be an input, 1 bit: the single clock; all logic is on its rising edge.
- REQ-004 `rst` SHALL be an input, 1 bit: reset, synchronous, active-high.
- REQ-005 `load` SHALL be an input, 1 bit: a one-cycle pulse that captures `word_in`.
- REQ-006 `word_in` SHALL be an input, 16 bits: the 16-bit encryption/decryption result to display.
- REQ-007 `busy` SHALL be an input, 1 bit: high while the cipher core is computing.
- REQ-008 `alph` SHALL be an output, 5 bits: the glyph code fed to the 7-segment decoder (0-15 hex, 16 'P', 17 '-').
- REQ-009 `anode` SHALL be an output, 4 bits: digit enables, active-low, with bit 0 the rightmost digit.

Function
- REQ-010 Prescaler `cnt` SHALL count 0..REFRESH_DIV-1 and wrap to 0; `tick` is asserted when cnt==REFRESH_DIV-1.
- REQ-011 Digit index `dig` (2 bits) SHALL increment on `tick`, wrapping 3->0, and SHALL not change otherwise.
- REQ-012 The FSM SHALL have three states, with these transitions and busy priority:
  - IDLE shows "----".
  - SHOW shows the latched word.
  - WAIT shows "----" while busy.
  - Any state with busy=1 goes to WAIT.
  - WAIT with busy=0 and load=1 goes to SHOW.
  - WAIT with busy=0 and load=0 goes to IDLE.
  - IDLE or SHOW with load=1 and busy=0 goes to SHOW.
- REQ-013 `word_q` SHALL capture `word_in` on any cycle with load=1 and busy=0; load with busy=1 SHALL be ignored and word_q held.
- REQ-014 In SHOW, the displayed code for digit d SHALL be zero-extended word_q[4d+3:4d], giving values 0-15.
- REQ-015 In IDLE and WAIT, the displayed code SHALL be 17 for every digit.
- REQ-016 `alph` and `anode` SHALL be registered, reflecting the cnt, dig and state of the previous cycle (1-cycle latency).
- REQ-017 `anode` SHALL be 4'b1111 when registered cnt < BLANK_CYC; otherwise it SHALL be all ones except bit dig=0.
- REQ-018 `alph` SHALL be updated every cycle, independent of blanking.
- REQ-019 A load during SHOW SHALL make the new nibble appear on `alph` two cycles after the load edge, with no interruption of the scan.
- REQ-020 `cnt` and `dig` SHALL never be reset or stalled by load or busy; only rst clears them.
- REQ-021 Code 16 ('P') SHALL never be produced by this revision; it is reserved.

Reset
- REQ-022 While rst=1 at a clock edge, the block SHALL set cnt=0, dig=0, state=IDLE, word_q=16'h0000, alph=17 and anode=4'b1111.
- REQ-023 Reset asserted mid-slot or mid-SHOW SHALL take effect at the next edge, discarding word_q.
- REQ-024 Scanning SHALL resume from digit 0, with cnt restarting at 0, the cycle after rst deasserts.

Structure
- REQ-025 Shared package `disp_pkg` SHALL hold:
  - ALPH_DASH=5'd17 and ALPH_P=5'd16;
  - NUM_DIGITS=4;
  - the FSM state encoding (IDLE, SHOW, WAIT, 2 bits).
- REQ-026 The prescaler (cnt plus tick) SHALL be one sub-module, `disp_refresh_tick`, parameterised by REFRESH_DIV.
- REQ-027 Digit select, FSM and output registers SHALL reside in disp_scan_mux.

Verification (REFRESH_DIV=8, BLANK_CYC=2)
- REQ-028 Reset scan: release rst and run 40 cycles -> alph=17 throughout; per 8-cycle slot, anode is 1111 for 2 cycles and then 1110/1101/1011/0111 in order, wrapping.
- REQ-029 Load display: load pulse with word_in=16'hA3F0 -> from 2 cycles later, alph is 0 on digit 0, F on digit 1, 3 on digit 2 and 10 on digit 3, each aligned with its active anode.
- REQ-030 Busy priority: in SHOW, raise busy for 20 cycles while pulsing load with 16'h1234 -> dashes shown; on busy fall with no load -> IDLE and dashes; word_q still 16'hA3F0.
- REQ-031 Busy exit with load: busy falls in the same cycle as load with 16'hBEEF -> SHOW directly, digits show F,E,E,B.
- REQ-032 Reset mid-slot: assert rst at cnt=5, dig=2 in SHOW -> next cycle anode=1111, alph=17; scan restarts at digit 0 and word_q=0.
- REQ-033 Blanking edge: BLANK_CYC=0 -> no all-off cycle; the anode changes exactly 1 cycle after each tick.
